// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths, entry layout and FSM states for the fetch queue.
package fetch_queue_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int INST_BYTES = 4;
  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] inst;
  } fq_entry_t;
  typedef enum logic {SETTLE, CAPTURE} fq_state_e;
endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush; head reads as zero when empty.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  assign count_d = count_q + CW'(wr_en_i) - CW'(rd_en_i);
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(wr_en_i);
      rd_q <= rd_q + PW'(rd_en_i);
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (wr_en_i) mem_q[wr_q] <= wr_data_i;
  assign rd_data_o = (count_q == '0) ? '0 : mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC sequencer and instruction buffer between fetch and decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic [31:0]            o_pc,
  input  logic [31:0]            i_fetch_inst,
  input  logic                   i_fetch_ready,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_pc,
  output logic                   o_valid,
  output logic [31:0]            o_inst,
  output logic [31:0]            o_inst_pc,
  input  logic                   i_accept,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  fq_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic push, pop;
  fq_entry_t head, tail;
  assign pop = o_valid && i_accept && !i_redirect;
  // A full buffer still has room when the head leaves in the same cycle.
  assign push = state_q == CAPTURE && i_fetch_ready && !i_redirect &&
                (o_count < CW'(DEPTH) || pop);
  assign tail = '{pc: pc_q, inst: i_fetch_inst};
  always_comb begin
    state_d = (i_redirect || push) ? SETTLE : CAPTURE;
    pc_d = i_redirect ? i_redirect_pc : push ? pc_q + 32'(INST_BYTES) : pc_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= SETTLE;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fq_entry_t))) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .flush_i(i_redirect),
    .wr_en_i(push),
    .wr_data_i(tail),
    .rd_en_i(pop),
    .rd_data_o(head),
    .count_o(o_count)
  );
  assign o_pc = pc_q;
  assign o_valid = o_count != '0;
  assign o_inst = head.inst;
  assign o_inst_pc = head.pc;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven vectors plus fetch-model sequences for fetch_queue.
module tb_fetch_queue;
  logic clk = 0;
  logic i_rst = 1, i_redirect = 0, i_accept = 0;
  logic [31:0] i_redirect_pc = 0;
  logic t_rdy = 0, use_model = 0;
  logic [31:0] t_inst = 0;
  logic [31:0] o_pc, o_inst, o_inst_pc;
  logic o_valid;
  logic [1:0] o_count;
  logic i_fetch_ready;
  logic [31:0] i_fetch_inst;
  int checks = 0, failures = 0;
  logic [31:0] f_pc = 32'h1;
  logic [2:0] f_cnt = 0;
  logic f_rdy = 0;
  logic [31:0] f_inst;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst(i_rst), .o_pc(o_pc),
    .i_fetch_inst(i_fetch_inst), .i_fetch_ready(i_fetch_ready),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .i_accept(i_accept), .o_count(o_count)
  );

  // Behavioural fetch over mem[i]=i[7:0]: ready goes stale for a cycle after a PC change.
  always @(posedge clk) begin
    if (f_pc != o_pc) begin
      f_pc <= o_pc;
      f_cnt <= 0;
      f_rdy <= 0;
    end else if (f_cnt < 3) f_cnt <= f_cnt + 1;
    else f_rdy <= 1;
  end
  assign f_inst = {f_pc[7:0], 8'(f_pc + 1), 8'(f_pc + 2), 8'(f_pc + 3)};
  assign i_fetch_ready = use_model ? f_rdy : t_rdy;
  assign i_fetch_inst = use_model ? f_inst : t_inst;

  typedef struct {
    logic redir; logic [31:0] rpc; logic rdy; logic [31:0] inst; logic acc;
    logic [31:0] e_pc; logic [1:0] e_cnt; logic [31:0] e_inst; logic [31:0] e_ipc;
  } vec_t;
  vec_t v[21];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [31:0] pc, input logic [1:0] cnt,
                         input logic [31:0] inst, input logic [31:0] ipc);
    chk({name, "_pc"}, o_pc, pc);
    chk({name, "_count"}, 32'(o_count), 32'(cnt));
    chk({name, "_valid"}, 32'(o_valid), 32'(cnt != 0));
    chk({name, "_inst"}, o_inst, inst);
    chk({name, "_ipc"}, o_inst_pc, ipc);
  endtask

  task automatic wait_cond(input logic want_valid, input logic [1:0] n, input string name);
    for (int c = 0; c < 200; c++) begin
      if (want_valid ? o_valid : (o_count == n)) break;
      step();
    end
    chk({name, "_reached"}, 32'(want_valid ? o_valid : (o_count == n)), 32'd1);
  endtask

  initial begin
    v[0]  = '{0, 0, 1, 32'hA0A0A0A0, 0, 32'h0,  0, 32'h0, 32'h0};
    v[1]  = '{0, 0, 1, 32'h11111111, 0, 32'h4,  1, 32'h11111111, 32'h0};
    v[2]  = '{0, 0, 1, 32'h22222222, 0, 32'h4,  1, 32'h11111111, 32'h0};
    v[3]  = '{0, 0, 1, 32'h22222222, 0, 32'h8,  2, 32'h11111111, 32'h0};
    v[4]  = '{0, 0, 0, 32'h0,        0, 32'h8,  2, 32'h11111111, 32'h0};
    v[5]  = '{0, 0, 1, 32'h33333333, 0, 32'h8,  2, 32'h11111111, 32'h0};
    v[6]  = '{0, 0, 1, 32'h33333333, 0, 32'h8,  2, 32'h11111111, 32'h0};
    v[7]  = '{0, 0, 1, 32'h33333333, 1, 32'hC,  2, 32'h22222222, 32'h4};
    v[8]  = '{0, 0, 0, 32'h0,        1, 32'hC,  1, 32'h33333333, 32'h8};
    v[9]  = '{0, 0, 0, 32'h0,        1, 32'hC,  0, 32'h0, 32'h0};
    v[10] = '{0, 0, 0, 32'h0,        1, 32'hC,  0, 32'h0, 32'h0};
    v[11] = '{0, 0, 1, 32'h44444444, 1, 32'h10, 1, 32'h44444444, 32'hC};
    v[12] = '{1, 32'h40, 1, 32'h99999999, 1, 32'h40, 0, 32'h0, 32'h0};
    v[13] = '{0, 0, 1, 32'h55555555, 0, 32'h40, 0, 32'h0, 32'h0};
    v[14] = '{0, 0, 1, 32'h55555555, 0, 32'h44, 1, 32'h55555555, 32'h40};
    v[15] = '{0, 0, 0, 32'h0,        0, 32'h44, 1, 32'h55555555, 32'h40};
    v[16] = '{1, 32'hFFFFFFFC, 1, 32'h88888888, 1, 32'hFFFFFFFC, 0, 32'h0, 32'h0};
    v[17] = '{0, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 32'h0, 32'h0};
    v[18] = '{0, 0, 1, 32'h66666666, 0, 32'h0,  1, 32'h66666666, 32'hFFFFFFFC};
    v[19] = '{0, 0, 1, 32'h77777777, 0, 32'h0,  1, 32'h66666666, 32'hFFFFFFFC};
    v[20] = '{0, 0, 1, 32'h77777777, 1, 32'h4,  1, 32'h77777777, 32'h0};

    // Reset beats a simultaneous redirect.
    i_rst = 1; i_redirect = 1; i_redirect_pc = 32'h80;
    step();
    chk_out("reset", 32'h0, 0, 32'h0, 32'h0);
    i_rst = 0; i_redirect = 0;

    for (int i = 0; i < 21; i++) begin
      i_redirect = v[i].redir; i_redirect_pc = v[i].rpc;
      t_rdy = v[i].rdy; t_inst = v[i].inst; i_accept = v[i].acc;
      step();
      chk_out($sformatf("vec%0d", i), v[i].e_pc, v[i].e_cnt, v[i].e_inst, v[i].e_ipc);
    end
    i_redirect = 0; t_rdy = 0; i_accept = 0;

    // In-order stream with the fetch model and decode always accepting.
    use_model = 1; i_rst = 1; step(); i_rst = 0;
    i_accept = 1;
    begin
      int k;
      logic [31:0] exp_inst [3];
      exp_inst[0] = 32'h00010203; exp_inst[1] = 32'h04050607; exp_inst[2] = 32'h08090A0B;
      k = 0;
      for (int c = 0; c < 200 && k < 3; c++) begin
        step();
        if (o_valid) begin
          chk($sformatf("stream%0d_ipc", k), o_inst_pc, 32'(4 * k));
          chk($sformatf("stream%0d_inst", k), o_inst, exp_inst[k]);
          chk($sformatf("stream%0d_pc", k), o_pc, 32'(4 * (k + 1)));
          k++;
        end
      end
      chk("stream_entries", 32'(k), 32'd3);
    end

    // Back-pressure: PC holds while full, then resumes after one accept.
    i_rst = 1; i_accept = 0; step(); i_rst = 0;
    wait_cond(0, 2, "bp_fill");
    repeat (30) step();
    chk_out("bp_hold", 32'h8, 2, 32'h00010203, 32'h0);
    i_accept = 1; step(); i_accept = 0;
    chk("bp_pop_ipc", o_inst_pc, 32'h4);
    chk("bp_pop_inst", o_inst, 32'h04050607);
    wait_cond(0, 2, "bp_refill");
    chk_out("bp_resume", 32'hC, 2, 32'h04050607, 32'h4);

    // Redirect while full flushes everything.
    i_redirect = 1; i_redirect_pc = 32'h40; step(); i_redirect = 0;
    chk_out("redir40", 32'h40, 0, 32'h0, 32'h0);
    i_accept = 1;
    wait_cond(1, 0, "redir40_head");
    chk("redir40_ipc", o_inst_pc, 32'h40);
    chk("redir40_inst", o_inst, 32'h40414243);

    // PC wraps past the top of the address space.
    i_redirect = 1; i_redirect_pc = 32'hFFFFFFFC; step(); i_redirect = 0;
    wait_cond(1, 0, "wrap_head");
    chk("wrap_ipc", o_inst_pc, 32'hFFFFFFFC);
    chk("wrap_inst", o_inst, 32'hFCFDFEFF);
    chk("wrap_pc", o_pc, 32'h0);

    // Reset two byte cycles into a fetch.
    i_redirect = 1; i_redirect_pc = 32'h20; step(); i_redirect = 0;
    step(); step(); step();
    i_rst = 1; step();
    chk_out("midrst", 32'h0, 0, 32'h0, 32'h0);
    i_rst = 0;
    wait_cond(1, 0, "midrst_head");
    chk("midrst_ipc", o_inst_pc, 32'h0);
    chk("midrst_inst", o_inst, 32'h00010203);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
